io_bus_arbiter: RTL and testbench

- Shares the single peripheral I/O bus between two masters: requester 0 (CPU exec I/O unit) and requester 1 (8237 DMA / debug master).
- Arbitrates round-robin, issues a one-cycle read/write strobe, then waits for the peripheral ack or a timeout.
- Returns read data and an ack pulse to the owning requester.
- Sits between the requesters and the port-address decode stage.

---
 rtl/io_bus_arbiter_pkg.sv | 29 ++
 rtl/io_bus_arbiter_rr_pick2.sv | 14 +
 rtl/io_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the peripheral I/O bus arbiter.
// Holds the FSM encoding, bus strobe codes and the per-requester request bundle.
package io_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Strobe encodings are {rd,wr}.
   localparam logic [1:0]  RW_NONE      = 2'b00;
   localparam logic [1:0]  RW_WR        = 2'b01;
   localparam logic [1:0]  RW_RD        = 2'b10;
   localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

   typedef struct packed {
      logic [1:0]  rw;
      logic [15:0] adr;
      logic [15:0] data;
      logic        bw;
   } reqBundle_t;

   // A request asserting both rd and wr is served as a read.
   function automatic logic [1:0] normRw(input logic [1:0] rw);
      return rw[1] ? RW_RD : rw;
   endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_pick2.sv
// Two-way round-robin winner select: prio breaks ties, a lone requester always wins.
module io_rr_pick2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = (req == 2'b11) ? prio : req[1];
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral I/O bus between the CPU I/O unit
// and the DMA/debug master; one-cycle strobe, then ack or timeout completion.
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 8
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iReq0,
   input  logic        iReq1,
   input  logic [1:0]  iRW0,
   input  logic [1:0]  iRW1,
   input  logic [15:0] iAdr0,
   input  logic [15:0] iAdr1,
   input  logic [15:0] iData0,
   input  logic [15:0] iData1,
   input  logic        iBW0,
   input  logic        iBW1,
   output logic        oAck0,
   output logic        oAck1,
   output logic [15:0] oData0,
   output logic [15:0] oData1,
   output logic [1:0]  oBusRW,
   output logic [15:0] oBusAdr,
   output logic [15:0] oBusData,
   output logic        oBusBW,
   input  logic        iBusAck,
   input  logic [15:0] iBusData,
   output logic        oOwner,
   output logic        oTimeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC);

   state_t           state;
   state_t           stateNext;
   logic             prio;
   logic [CNT_W-1:0] counter;

   logic             winner;
   logic             anyReq;
   reqBundle_t       req0;
   reqBundle_t       req1;
   reqBundle_t       winReq;

   logic             grant;
   logic             ackHit;
   logic             toHit;
   logic [15:0]      doneData;

   io_rr_pick2 uPick (
      .req    ({iReq1, iReq0}),
      .prio   (prio),
      .winner (winner),
      .valid  (anyReq)
   );

   always_comb begin
      req0   = '{rw: iRW0, adr: iAdr0, data: iData0, bw: iBW0};
      req1   = '{rw: iRW1, adr: iAdr1, data: iData1, bw: iBW1};
      winReq = winner ? req1 : req0;
   end

   // NOTE: every signal is given a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      stateNext = state;
      grant     = 1'b0;
      ackHit    = 1'b0;
      toHit     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (anyReq) begin
               grant     = 1'b1;
               stateNext = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A real ack on the last counted cycle beats the timeout.
            if (iBusAck) begin
               ackHit    = 1'b1;
               stateNext = ST_DONE;
            end else if (counter == TIMEOUT_LAST) begin
               toHit     = 1'b1;
               stateNext = ST_DONE;
            end
         end
         ST_DONE: stateNext = ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
      doneData = ackHit ? iBusData : TIMEOUT_DATA;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state    <= ST_IDLE;
         prio     <= 1'b0;
         counter  <= '0;
         oBusRW   <= RW_NONE;
         oBusAdr  <= '0;
         oBusData <= '0;
         oBusBW   <= 1'b0;
         oAck0    <= 1'b0;
         oAck1    <= 1'b0;
         oData0   <= '0;
         oData1   <= '0;
         oOwner   <= 1'b0;
         oTimeout <= 1'b0;
      end else begin
         state    <= stateNext;
         oBusRW   <= RW_NONE;
         oAck0    <= 1'b0;
         oAck1    <= 1'b0;
         oTimeout <= 1'b0;

         if (grant) begin
            oBusRW   <= normRw(winReq.rw);
            oBusAdr  <= winReq.adr;
            oBusData <= winReq.data;
            oBusBW   <= winReq.bw;
            oOwner   <= winner;
            prio     <= ~winner;
            counter  <= '0;
         end

         if (state == ST_WAIT && !ackHit && !toHit) begin
            counter <= counter + CNT_W'(1);
         end

         // Only the owner's return path moves; the other requester's outputs stay put.
         if (ackHit || toHit) begin
            oTimeout <= toHit;
            if (oOwner) begin
               oData1 <= doneData;
               oAck1  <= 1'b1;
            end else begin
               oData0 <= doneData;
               oAck0  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed-vector bench for io_bus_arbiter: reset, read, contention, timeout,
// ack/timeout race, write with stray ack, and reset in the middle of a transaction.
module tb_io_bus_arbiter;

   localparam int TIMEOUT_CYC = 255;

   logic        iClk = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iReq0 = 1'b0, iReq1 = 1'b0;
   logic [1:0]  iRW0 = '0, iRW1 = '0;
   logic [15:0] iAdr0 = '0, iAdr1 = '0;
   logic [15:0] iData0 = '0, iData1 = '0;
   logic        iBW0 = 1'b0, iBW1 = 1'b0;
   logic        oAck0, oAck1;
   logic [15:0] oData0, oData1;
   logic [1:0]  oBusRW;
   logic [15:0] oBusAdr, oBusData;
   logic        oBusBW;
   logic        iBusAck = 1'b0;
   logic [15:0] iBusData = '0;
   logic        oOwner, oTimeout;

   int checks = 0;
   int passed = 0;

   logic [70:0] outVec;
   assign outVec = {oBusRW, oBusAdr, oBusData, oBusBW, oAck0, oAck1,
                    oData0, oData1, oOwner, oTimeout};

   io_bus_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
      .iClk(iClk), .iRst_n(iRst_n),
      .iReq0(iReq0), .iReq1(iReq1), .iRW0(iRW0), .iRW1(iRW1),
      .iAdr0(iAdr0), .iAdr1(iAdr1), .iData0(iData0), .iData1(iData1),
      .iBW0(iBW0), .iBW1(iBW1),
      .oAck0(oAck0), .oAck1(oAck1), .oData0(oData0), .oData1(oData1),
      .oBusRW(oBusRW), .oBusAdr(oBusAdr), .oBusData(oBusData), .oBusBW(oBusBW),
      .iBusAck(iBusAck), .iBusData(iBusData),
      .oOwner(oOwner), .oTimeout(oTimeout)
   );

   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic test_reset();
      iRst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (outVec !== 71'd0) $display("FAIL reset_outputs got=%h want=0", outVec);
      else passed++;
      iRst_n = 1'b1;
      tick();
      checks++;
      if (outVec !== 71'd0) $display("FAIL idle_after_reset got=%h want=0", outVec);
      else passed++;
   endtask

   task automatic test_single_read();
      iReq0 = 1'b1; iRW0 = 2'b10; iAdr0 = 16'h0040;
      tick();
      checks++;
      if ({oBusRW, oBusAdr, oOwner} !== {2'b10, 16'h0040, 1'b0})
         $display("FAIL read_grant got rw=%b adr=%h own=%b want rw=10 adr=0040 own=0",
                  oBusRW, oBusAdr, oOwner);
      else passed++;
      tick();
      checks++;
      if ({oBusRW, oAck0} !== 3'b000)
         $display("FAIL read_strobe_width got rw=%b ack0=%b want rw=00 ack0=0", oBusRW, oAck0);
      else passed++;
      iBusAck = 1'b1; iBusData = 16'h00A5;
      tick();
      checks++;
      if ({oAck0, oAck1, oData0} !== {1'b1, 1'b0, 16'h00A5})
         $display("FAIL read_ack got ack0=%b ack1=%b d0=%h want 1 0 00a5", oAck0, oAck1, oData0);
      else passed++;
      iBusAck = 1'b0; iBusData = 16'h0; iReq0 = 1'b0;
      tick();
      checks++;
      if ({oAck0, oAck1, oData0} !== {1'b0, 1'b0, 16'h00A5})
         $display("FAIL read_done got ack0=%b ack1=%b d0=%h want 0 0 00a5", oAck0, oAck1, oData0);
      else passed++;
   endtask

   task automatic test_contention();
      iRst_n = 1'b0;
      tick();
      iRst_n = 1'b1;
      iReq0 = 1'b1; iRW0 = 2'b10; iAdr0 = 16'h0010;
      iReq1 = 1'b1; iRW1 = 2'b10; iAdr1 = 16'h0020;
      tick();
      checks++;
      if ({oOwner, oBusAdr} !== {1'b0, 16'h0010})
         $display("FAIL contention_first got own=%b adr=%h want own=0 adr=0010", oOwner, oBusAdr);
      else passed++;
      iBusAck = 1'b1; iBusData = 16'h1111;
      tick();
      checks++;
      if ({oAck0, oAck1, oData0} !== {1'b1, 1'b0, 16'h1111})
         $display("FAIL contention_ack0 got ack0=%b ack1=%b d0=%h want 1 0 1111", oAck0, oAck1, oData0);
      else passed++;
      iBusAck = 1'b0; iReq0 = 1'b0;
      tick();
      // Requester 0 comes back with a new request while 1 is still pending.
      iReq0 = 1'b1; iAdr0 = 16'h0030;
      tick();
      checks++;
      if ({oOwner, oBusAdr} !== {1'b1, 16'h0020})
         $display("FAIL contention_second got own=%b adr=%h want own=1 adr=0020", oOwner, oBusAdr);
      else passed++;
      iBusAck = 1'b1; iBusData = 16'h2222;
      tick();
      checks++;
      if ({oAck0, oAck1, oData0, oData1} !== {1'b0, 1'b1, 16'h1111, 16'h2222})
         $display("FAIL contention_ack1 got ack0=%b ack1=%b d0=%h d1=%h want 0 1 1111 2222",
                  oAck0, oAck1, oData0, oData1);
      else passed++;
      iBusAck = 1'b0; iReq1 = 1'b0;
      tick();
      tick();
      checks++;
      if ({oOwner, oBusAdr} !== {1'b0, 16'h0030})
         $display("FAIL contention_third got own=%b adr=%h want own=0 adr=0030", oOwner, oBusAdr);
      else passed++;
      iBusAck = 1'b1; iBusData = 16'h3333;
      tick();
      checks++;
      if ({oAck0, oAck1, oData0, oData1} !== {1'b1, 1'b0, 16'h3333, 16'h2222})
         $display("FAIL contention_ack2 got ack0=%b ack1=%b d0=%h d1=%h want 1 0 3333 2222",
                  oAck0, oAck1, oData0, oData1);
      else passed++;
      iBusAck = 1'b0; iReq0 = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int   ackEdge = 0;
      logic seenTo  = 1'b0;
      logic [15:0] seenData = '0;
      logic seenAck0 = 1'b0;
      iReq1 = 1'b1; iRW1 = 2'b10; iAdr1 = 16'h02F8;
      tick();
      checks++;
      if ({oOwner, oBusAdr} !== {1'b1, 16'h02F8})
         $display("FAIL timeout_grant got own=%b adr=%h want own=1 adr=02f8", oOwner, oBusAdr);
      else passed++;
      for (int e = 2; e <= TIMEOUT_CYC + 40 && ackEdge == 0; e++) begin
         tick();
         if (oAck1 || oTimeout) begin
            ackEdge  = e;
            seenTo   = oTimeout;
            seenData = oData1;
            seenAck0 = oAck0;
         end
      end
      checks++;
      if (ackEdge != TIMEOUT_CYC + 2)
         $display("FAIL timeout_latency got=%0d want=%0d", ackEdge, TIMEOUT_CYC + 2);
      else passed++;
      checks++;
      if ({seenTo, seenData, seenAck0} !== {1'b1, 16'hFFFF, 1'b0})
         $display("FAIL timeout_result got to=%b d1=%h ack0=%b want 1 ffff 0", seenTo, seenData, seenAck0);
      else passed++;
      iReq1 = 1'b0;
      tick();
      checks++;
      if ({oAck1, oTimeout} !== 2'b00)
         $display("FAIL timeout_clear got ack1=%b to=%b want 0 0", oAck1, oTimeout);
      else passed++;
   endtask

   task automatic test_ack_on_timeout();
      logic early = 1'b0;
      iReq0 = 1'b1; iRW0 = 2'b10; iAdr0 = 16'h0050;
      tick();
      for (int e = 2; e <= TIMEOUT_CYC + 1; e++) begin
         tick();
         if (oAck0 || oTimeout) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) $display("FAIL race_early_ack got=1 want=0");
      else passed++;
      iBusAck = 1'b1; iBusData = 16'h1234;
      tick();
      checks++;
      if ({oAck0, oTimeout, oData0} !== {1'b1, 1'b0, 16'h1234})
         $display("FAIL race_ack_wins got ack0=%b to=%b d0=%h want 1 0 1234", oAck0, oTimeout, oData0);
      else passed++;
      iBusAck = 1'b0; iReq0 = 1'b0;
      tick();
   endtask

   task automatic test_write_stray_ack();
      iBusAck = 1'b1; iBusData = 16'hDEAD;
      tick();
      checks++;
      if ({oAck0, oAck1, oBusRW, oData0} !== {1'b0, 1'b0, 2'b00, 16'h1234})
         $display("FAIL stray_ack got ack0=%b ack1=%b rw=%b d0=%h want 0 0 00 1234",
                  oAck0, oAck1, oBusRW, oData0);
      else passed++;
      iBusAck = 1'b0;
      iReq0 = 1'b1; iRW0 = 2'b01; iAdr0 = 16'h0021; iData0 = 16'h00FF; iBW0 = 1'b1;
      tick();
      checks++;
      if ({oBusRW, oBusAdr, oBusData, oBusBW} !== {2'b01, 16'h0021, 16'h00FF, 1'b1})
         $display("FAIL write_grant got rw=%b adr=%h dat=%h bw=%b want 01 0021 00ff 1",
                  oBusRW, oBusAdr, oBusData, oBusBW);
      else passed++;
      tick();
      checks++;
      if ({oBusRW, oAck0} !== 3'b000)
         $display("FAIL write_strobe_width got rw=%b ack0=%b want 00 0", oBusRW, oAck0);
      else passed++;
      iBusAck = 1'b1; iBusData = 16'h0055;
      tick();
      checks++;
      if ({oAck0, oData0} !== {1'b1, 16'h0055})
         $display("FAIL write_ack got ack0=%b d0=%h want 1 0055", oAck0, oData0);
      else passed++;
      iBusAck = 1'b0; iReq0 = 1'b0; iData0 = 16'h0; iAdr0 = 16'h0;
      tick();
      checks++;
      if ({oAck0, oBusAdr, oBusData, oBusBW} !== {1'b0, 16'h0021, 16'h00FF, 1'b1})
         $display("FAIL write_hold got ack0=%b adr=%h dat=%h bw=%b want 0 0021 00ff 1",
                  oAck0, oBusAdr, oBusData, oBusBW);
      else passed++;
   endtask

   task automatic test_reset_mid_wait();
      iReq1 = 1'b1; iRW1 = 2'b11; iAdr1 = 16'h0060;
      tick();
      checks++;
      if ({oBusRW, oOwner} !== {2'b10, 1'b1})
         $display("FAIL rw11_as_read got rw=%b own=%b want 10 1", oBusRW, oOwner);
      else passed++;
      tick();
      iRst_n = 1'b0;
      tick();
      checks++;
      if (outVec !== 71'd0) $display("FAIL mid_wait_reset got=%h want=0", outVec);
      else passed++;
      iRst_n = 1'b1; iReq1 = 1'b0;
      iBusAck = 1'b1; iBusData = 16'hBEEF;
      tick();
      iBusAck = 1'b0;
      tick();
      checks++;
      if (outVec !== 71'd0) $display("FAIL late_ack_ignored got=%h want=0", outVec);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_timeout();
      test_ack_on_timeout();
      test_write_stray_ack();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
